writeback_stage: RTL and testbench

Final stage of the multicycle RV32I datapath; drives the register file write port (active-low write enable, destination select, write data).
Selects the result source (ALU, load data, PC+4, immediate), aligns and sign/zero-extends load data, and issues exactly one write strobe per instruction.
Sits between the control matrix/memory interface and the 32x32 register file.
Includes a bounded wait for memory read data with timeout.

---
 rtl/writeback_stage.sv | 180 ++++++++++++++++++
 tb/tb_writeback_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: selects the result source, formats load data and drives the register file write port.
// Optional misaligned-load trap: define WB_MISALIGN_TRAP_EN.
module writeback_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SELECT_SIZE    = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wb_valid_i,
  output logic                   wb_ready_o,
  input  logic [1:0]             wb_sel_i,
  input  logic [2:0]             funct3_i,
  input  logic [SELECT_SIZE-1:0] rd_i,
  input  logic [DATA_WIDTH-1:0]  alu_result_i,
  input  logic [DATA_WIDTH-1:0]  pc_plus4_i,
  input  logic [DATA_WIDTH-1:0]  imm_i,
  input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
  input  logic                   mem_rvalid_i,
  output logic                   reg_we_no,
  output logic [SELECT_SIZE-1:0] reg_dst_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   wb_done_o,
`ifdef WB_MISALIGN_TRAP_EN
  output logic                   misalign_o,
`endif
  output logic                   timeout_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] SelAlu  = 2'b00;
  localparam logic [1:0] SelLoad = 2'b01;
  localparam logic [1:0] SelPc4  = 2'b10;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  typedef enum logic [1:0] {StIdle, StWaitMem, StWrite} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [1:0]             off_q, off_d;
  logic [SELECT_SIZE-1:0] rd_q, rd_d;
  logic [SELECT_SIZE-1:0] dst_q, dst_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_fmt;
  logic [DATA_WIDTH-1:0] operand;
  logic                  timeout;
`ifdef WB_MISALIGN_TRAP_EN
  logic                  misaligned;
  logic                  misalign;
`endif

  always_comb begin
    unique case (off_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    unique case (funct3_q)
      F3Lb:    ld_fmt = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F3Lbu:   ld_fmt = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      F3Lh:    ld_fmt = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      F3Lhu:   ld_fmt = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      F3Lw:    ld_fmt = mem_rdata_i;
      default: ld_fmt = mem_rdata_i;
    endcase
  end

  always_comb begin
    unique case (wb_sel_i)
      SelAlu:  operand = alu_result_i;
      SelPc4:  operand = pc_plus4_i;
      default: operand = imm_i;
    endcase
  end

`ifdef WB_MISALIGN_TRAP_EN
  assign misaligned = (((funct3_q == F3Lh) || (funct3_q == F3Lhu)) && off_q[0]) ||
                      ((funct3_q == F3Lw) && (off_q != 2'd0));
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    dst_d    = dst_q;
    data_d   = data_q;
    timeout  = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
    misalign = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (wb_valid_i) begin
          funct3_d = funct3_i;
          off_d    = alu_result_i[1:0];
          rd_d     = rd_i;
          if (wb_sel_i == SelLoad) begin
            cnt_d   = '0;
            state_d = StWaitMem;
          end else begin
            // Output registers only change on entry to WRITE so they hold between writes.
            data_d  = operand;
            dst_d   = rd_i;
            state_d = StWrite;
          end
        end
      end
      StWaitMem: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid_i) begin
`ifdef WB_MISALIGN_TRAP_EN
          if (misaligned) begin
            misalign = 1'b1;
            state_d  = StIdle;
          end else begin
            data_d  = ld_fmt;
            dst_d   = rd_q;
            state_d = StWrite;
          end
`else
          data_d  = ld_fmt;
          dst_d   = rd_q;
          state_d = StWrite;
`endif
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = StIdle;
        end
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      rd_q     <= '0;
      dst_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      dst_q    <= dst_d;
      data_q   <= data_d;
    end
  end

  assign wb_ready_o = (state_q == StIdle);
  assign wb_done_o  = (state_q == StWrite);
  // x0 writes still complete but never strobe the register file.
  assign reg_we_no  = !((state_q == StWrite) && (dst_q != '0));
  assign reg_dst_o  = dst_q;
  assign data_o     = data_q;
  assign timeout_o  = timeout;
`ifdef WB_MISALIGN_TRAP_EN
  assign misalign_o = misalign;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed test-plan cases, then randomized transactions
// checked against a transaction-level reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_sel;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu, pc4, imm, mem_rdata;
  logic        mem_rvalid;
  logic        we_n;
  logic [4:0]  dst;
  logic [31:0] data;
  logic        done;
  logic        timeout;
`ifdef WB_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_data;
  logic [4:0]  exp_dst;

  always #5 clk = ~clk;

  writeback_stage #(
    .DATA_WIDTH(32),
    .SELECT_SIZE(5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wb_valid_i  (wb_valid),
    .wb_ready_o  (wb_ready),
    .wb_sel_i    (wb_sel),
    .funct3_i    (funct3),
    .rd_i        (rd),
    .alu_result_i(alu),
    .pc_plus4_i  (pc4),
    .imm_i       (imm),
    .mem_rdata_i (mem_rdata),
    .mem_rvalid_i(mem_rvalid),
    .reg_we_no   (we_n),
    .reg_dst_o   (dst),
    .data_o      (data),
    .wb_done_o   (done),
`ifdef WB_MISALIGN_TRAP_EN
    .misalign_o  (misalign),
`endif
    .timeout_o   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load formatting from the RV32I rules, using shifts and arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic idle_checks(input string tag);
    chk({tag, "_ready"}, 32'(wb_ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_we_n"}, 32'(we_n), 32'd1);
    chk({tag, "_data_hold"}, data, exp_data);
    chk({tag, "_dst_hold"}, 32'(dst), 32'(exp_dst));
  endtask

  // Issue one writeback; delay = WAIT_MEM cycles before rvalid (>=16 means never).
  task automatic run_txn(input logic [1:0] s, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] p, input logic [31:0] i,
                         input logic [31:0] w, input int delay);
    logic [31:0] expv;
    bit          wrote;
    wb_valid = 1'b1; wb_sel = s; funct3 = f3; rd = r; alu = a; pc4 = p; imm = i;
    #1;
    chk("accept_ready", 32'(wb_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs after accept: the DUT must use captured values.
    wb_valid = 1'b0; wb_sel = 2'($urandom); funct3 = 3'($urandom); rd = 5'($urandom);
    alu = $urandom; pc4 = $urandom; imm = $urandom;
    wrote = 1'b1;
    if (s == 2'b01) begin
      expv  = ref_load(f3, int'(a[1:0]), w);
      wrote = (delay < 16);
      for (int k = 0; k < 16; k++) begin
        mem_rvalid = (k == delay);
        mem_rdata  = (k == delay) ? w : $urandom;
        #1;
        chk("wait_ready", 32'(wb_ready), 32'd0);
        chk("wait_we_n", 32'(we_n), 32'd1);
        chk("wait_timeout", 32'(timeout), 32'((k == 15) && (delay > 15)));
        @(posedge clk); #1;
        if (k == delay) break;
      end
      mem_rvalid = 1'b0;
    end else begin
      expv = (s == 2'b00) ? a : (s == 2'b10) ? p : i;
    end
    if (wrote) begin
      exp_data = expv;
      exp_dst  = r;
      chk("write_we_n", 32'(we_n), 32'(r == 5'd0));
      chk("write_dst", 32'(dst), 32'(r));
      chk("write_data", data, expv);
      chk("write_done", 32'(done), 32'd1);
      chk("write_timeout", 32'(timeout), 32'd0);
      @(posedge clk); #1;
    end
    idle_checks("after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    rst_n = 1'b0; wb_valid = 1'b0; wb_sel = '0; funct3 = '0; rd = '0;
    alu = '0; pc4 = '0; imm = '0; mem_rdata = '0; mem_rvalid = 1'b0;
    exp_data = '0; exp_dst = '0;
    #12;
    chk("rst_ready", 32'(wb_ready), 32'd1);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_dst", 32'(dst), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed test-plan cases.
    run_txn(2'b00, 3'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 0);
    run_txn(2'b01, 3'd0, 5'd3, 32'h0000_0002, 32'h0, 32'h0, 32'h0080_0000, 3);
    run_txn(2'b01, 3'd4, 5'd3, 32'h0000_0002, 32'h0, 32'h0, 32'h0080_0000, 3);
    run_txn(2'b01, 3'd5, 5'd4, 32'h0000_0002, 32'h0, 32'h0, 32'h8001_7FFF, 1);
    run_txn(2'b01, 3'd1, 5'd4, 32'h0000_0002, 32'h0, 32'h0, 32'h8001_7FFF, 0);
    run_txn(2'b01, 3'd1, 5'd4, 32'h0000_0000, 32'h0, 32'h0, 32'h8001_7FFF, 2);
    run_txn(2'b01, 3'd2, 5'd6, 32'h0000_0003, 32'h0, 32'h0, 32'hDEAD_BEEF, 15);
    run_txn(2'b01, 3'd2, 5'd6, 32'h0000_0000, 32'h0, 32'h0, 32'hCAFE_F00D, 99);
    run_txn(2'b11, 3'd0, 5'd31, 32'h0, 32'h0, 32'hABCD_E000, 32'h0, 0);

    // x0 write with wb_valid held through WRITE: second accept only after IDLE.
    wb_valid = 1'b1; wb_sel = 2'b10; rd = 5'd0; pc4 = 32'h0000_0104;
    @(posedge clk); #1;
    wb_sel = 2'b00; rd = 5'd7; alu = 32'h5555_AAAA;
    chk("x0_we_n", 32'(we_n), 32'd1);
    chk("x0_done", 32'(done), 32'd1);
    chk("x0_data", data, 32'h0000_0104);
    @(posedge clk); #1;
    chk("b2b_idle_ready", 32'(wb_ready), 32'd1);
    chk("b2b_idle_done", 32'(done), 32'd0);
    chk("b2b_idle_data", data, 32'h0000_0104);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    chk("b2b_we_n", 32'(we_n), 32'd0);
    chk("b2b_dst", 32'(dst), 32'd7);
    chk("b2b_data", data, 32'h5555_AAAA);
    @(posedge clk); #1;
    exp_data = 32'h5555_AAAA; exp_dst = 5'd7;
    idle_checks("b2b_end");

    // Asynchronous reset in the middle of a load wait.
    wb_valid = 1'b1; wb_sel = 2'b01; funct3 = 3'd2; rd = 5'd9;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    exp_data = '0; exp_dst = '0;
    idle_checks("async_rst");
    chk("async_rst_timeout", 32'(timeout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      idle_checks("post_rst");
    end
    mem_rvalid = 1'b0;

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      run_txn(2'($urandom), f3_tab[$urandom_range(0, 7)], 5'($urandom), $urandom, $urandom,
              $urandom, $urandom, ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
